// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: access-size encodings,
// default memory depth and the index-width helper.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_HALF = 2'b01,
    MEM_BYTE = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  localparam int unsigned DEPTH_DEFAULT = 1024;

  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/data_memory_ram.sv
// Word-organised data memory: byte-enabled synchronous write, asynchronous read,
// single shared address. Contents are not reset; writes are blocked while in reset.
module data_memory_ram
  import mem_stage_pkg::*;
#(
  parameter int unsigned Depth = DEPTH_DEFAULT,
  parameter int unsigned AddrW = idx_width(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_ni && we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: alignment check, store lane steering, load extraction
// and extension, sticky misalignment fault and the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic        MemToReg,
  input  logic        RegWrite,
  input  logic [4:0]  RegDest,
  input  logic [31:0] ALUResult,
  input  logic [31:0] StoreData,
  output logic [31:0] MEM_ReadData,
  output logic [31:0] WB_ReadData,
  output logic [31:0] WB_ALUResult,
  output logic [4:0]  WB_RegDest,
  output logic        WB_RegWrite,
  output logic        WB_MemToReg,
  output logic        AlignFault,
  output logic [31:0] FaultAddr
);

  localparam int unsigned IdxW = idx_width(DEPTH);

  mem_size_e       size;
  logic [1:0]      lane;
  logic [IdxW-1:0] word_idx;
  logic            misaligned;
  logic            access;
  logic            ram_we;
  logic [3:0]      ram_be;
  logic [31:0]     ram_wdata;
  logic [31:0]     ram_rdata;
  logic [31:0]     rd_shift;
  logic [31:0]     load_ext;
  logic [31:0]     load_data;

  logic [31:0] wb_read_data_q, wb_read_data_d;
  logic [31:0] wb_alu_result_q, wb_alu_result_d;
  logic [4:0]  wb_reg_dest_q, wb_reg_dest_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic        wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic        align_fault_q, align_fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  // High address bits are ignored so the address wraps modulo DEPTH words.
  logic unused_addr;
  assign unused_addr = ^ALUResult[31:IdxW+2];

  assign size     = mem_size_e'(MemSize);
  assign lane     = ALUResult[1:0];
  assign word_idx = ALUResult[IdxW+1:2];
  assign access   = MemRead | MemWrite;

  always_comb begin
    misaligned = 1'b0;
    ram_be     = 4'hF;
    ram_wdata  = StoreData;
    unique case (size)
      MEM_HALF: begin
        misaligned = lane[0];
        ram_be     = lane[1] ? 4'b1100 : 4'b0011;
        ram_wdata  = {2{StoreData[15:0]}};
      end
      MEM_BYTE: begin
        misaligned = 1'b0;
        ram_be     = 4'b0001 << lane;
        ram_wdata  = {4{StoreData[7:0]}};
      end
      default: begin
        // Reserved encoding behaves as a word access.
        misaligned = |lane;
        ram_be     = 4'hF;
        ram_wdata  = StoreData;
      end
    endcase
  end

  assign ram_we = MemWrite & ~misaligned;

  data_memory_ram #(
    .Depth (DEPTH),
    .AddrW (IdxW)
  ) u_ram (
    .clk_i   (Clock),
    .rst_ni  (Reset),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (word_idx),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign rd_shift = ram_rdata >> {lane, 3'b000};

  always_comb begin
    load_ext = ram_rdata;
    unique case (size)
      MEM_HALF: load_ext = {{16{MemSigned & rd_shift[15]}}, rd_shift[15:0]};
      MEM_BYTE: load_ext = {{24{MemSigned & rd_shift[7]}}, rd_shift[7:0]};
      default:  load_ext = ram_rdata;
    endcase
  end

  // Read is of the pre-write contents, so a simultaneous store returns old data.
  assign load_data    = (MemRead && !misaligned) ? load_ext : 32'h0;
  assign MEM_ReadData = load_data;

  always_comb begin
    wb_read_data_d  = load_data;
    wb_alu_result_d = ALUResult;
    wb_reg_dest_d   = RegDest;
    wb_reg_write_d  = RegWrite & ~(misaligned & access);
    wb_mem_to_reg_d = MemToReg;
    align_fault_d   = align_fault_q;
    fault_addr_d    = fault_addr_q;
    if (misaligned && access) begin
      align_fault_d = 1'b1;
      if (!align_fault_q) begin
        fault_addr_d = ALUResult;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wb_read_data_q  <= 32'h0;
      wb_alu_result_q <= 32'h0;
      wb_reg_dest_q   <= 5'h0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      align_fault_q   <= 1'b0;
      fault_addr_q    <= 32'h0;
    end else begin
      wb_read_data_q  <= wb_read_data_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_reg_dest_q   <= wb_reg_dest_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      align_fault_q   <= align_fault_d;
      fault_addr_q    <= fault_addr_d;
    end
  end

  assign WB_ReadData  = wb_read_data_q;
  assign WB_ALUResult = wb_alu_result_q;
  assign WB_RegDest   = wb_reg_dest_q;
  assign WB_RegWrite  = wb_reg_write_q;
  assign WB_MemToReg  = wb_mem_to_reg_q;
  assign AlignFault   = align_fault_q;
  assign FaultAddr    = fault_addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed literal checks plus randomized traffic against a
// byte-addressed reference model with per-byte known flags.
module tb_mem_stage;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n, mem_rd, mem_wr, mem_sgn, m2r, rw;
  logic [1:0]  msize;
  logic [4:0]  dst;
  logic [31:0] addr, sdata;
  logic [31:0] mem_rdata, wb_rdata, wb_alu, faddr;
  logic [4:0]  wb_dst;
  logic        wb_rw, wb_m2r, afault;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [7:0]  mbyte  [DEPTH*4];
  bit          mknown [DEPTH*4];
  logic [31:0] e_rd, e_alu, e_faddr;
  logic [4:0]  e_dst;
  bit          e_rd_known, e_rw, e_m2r, e_fault;

  always #5 clk = ~clk;

  mem_stage #(.DEPTH(DEPTH)) dut (
    .Clock        (clk),
    .Reset        (rst_n),
    .MemRead      (mem_rd),
    .MemWrite     (mem_wr),
    .MemSize      (msize),
    .MemSigned    (mem_sgn),
    .MemToReg     (m2r),
    .RegWrite     (rw),
    .RegDest      (dst),
    .ALUResult    (addr),
    .StoreData    (sdata),
    .MEM_ReadData (mem_rdata),
    .WB_ReadData  (wb_rdata),
    .WB_ALUResult (wb_alu),
    .WB_RegDest   (wb_dst),
    .WB_RegWrite  (wb_rw),
    .WB_MemToReg  (wb_m2r),
    .AlignFault   (afault),
    .FaultAddr    (faddr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'b01) return 2;
    if (sz == 2'b10) return 1;
    return 4;
  endfunction

  function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b10) return 1'b0;
    if (sz == 2'b01) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic int base_of(input logic [31:0] a);
    int widx;
    widx = int'(a >> 2) % DEPTH;
    return widx * 4 + int'(a[1:0]);
  endfunction

  // Expected combinational read for the inputs currently applied.
  function automatic void model_read(output logic [31:0] val, output bit known);
    int n, b;
    logic [31:0] mask;
    val   = 32'h0;
    known = 1'b1;
    if (!mem_rd || is_mis(msize, addr)) return;
    n = nbytes(msize);
    b = base_of(addr);
    for (int i = 0; i < n; i++) begin
      val   = val | (32'(mbyte[b+i]) << (8 * i));
      known = known & mknown[b+i];
    end
    if (n < 4) begin
      mask = (32'h1 << (8 * n)) - 32'h1;
      if (mem_sgn && val[8*n-1]) val = val | ~mask;
    end
  endfunction

  // Advance the model across one rising edge using the inputs present at it.
  task automatic model_edge();
    bit mis, acc;
    int n, b;
    if (!rst_n) begin
      e_rd = 0; e_rd_known = 1; e_alu = 0; e_dst = 0; e_rw = 0; e_m2r = 0;
      e_fault = 0; e_faddr = 0;
      return;
    end
    mis = is_mis(msize, addr);
    acc = mem_rd | mem_wr;
    model_read(e_rd, e_rd_known);
    e_alu = addr;
    e_dst = dst;
    e_m2r = m2r;
    e_rw  = rw && !(mis && acc);
    if (mem_wr && !mis) begin
      n = nbytes(msize);
      b = base_of(addr);
      for (int i = 0; i < n; i++) begin
        mbyte[b+i]  = sdata[8*i +: 8];
        mknown[b+i] = 1'b1;
      end
    end
    if (mis && acc) begin
      if (!e_fault) e_faddr = addr;
      e_fault = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] v;
    bit k;
    if (chk_en) begin
      model_read(v, k);
      if (k) chk("mem_rdata", mem_rdata, v);
      if (e_rd_known) chk("wb_rdata", wb_rdata, e_rd);
      chk("wb_alu", wb_alu, e_alu);
      chk("wb_dst", 32'(wb_dst), 32'(e_dst));
      chk("wb_rw", 32'(wb_rw), 32'(e_rw));
      chk("wb_m2r", 32'(wb_m2r), 32'(e_m2r));
      chk("afault", 32'(afault), 32'(e_fault));
      chk("faddr", faddr, e_faddr);
    end
  end

  task automatic drv(input bit r, input bit rd, input bit wr, input logic [1:0] sz,
                     input bit sg, input bit mr, input bit w, input logic [4:0] d,
                     input logic [31:0] a, input logic [31:0] sd);
    rst_n = r; mem_rd = rd; mem_wr = wr; msize = sz; mem_sgn = sg;
    m2r = mr; rw = w; dst = d; addr = a; sdata = sd;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH * 4; i++) begin
      mbyte[i]  = 8'h0;
      mknown[i] = 1'b0;
    end
    drv(0, 0, 0, 2'b00, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    tick();
    chk_en = 1'b1;
    drv(0, 0, 0, 2'b00, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    chk("rst_wb_rw", 32'(wb_rw), 32'h0);
    chk("rst_afault", 32'(afault), 32'h0);
    tick();

    // Word store then loads with extension
    drv(1, 0, 1, 2'b00, 0, 0, 0, 5'd0, 32'h10, 32'hDEADBEEF); tick();
    drv(1, 1, 0, 2'b00, 0, 1, 1, 5'd5, 32'h10, 32'h0);
    chk("lw_10", mem_rdata, 32'hDEADBEEF); tick();
    drv(1, 1, 0, 2'b10, 1, 1, 1, 5'd6, 32'h11, 32'h0);
    chk("wb_lw_10", wb_rdata, 32'hDEADBEEF);
    chk("wb_lw_rw", 32'(wb_rw), 32'h1);
    chk("lb_11", mem_rdata, 32'hFFFFFFBE); tick();
    drv(1, 1, 0, 2'b10, 0, 1, 1, 5'd7, 32'h11, 32'h0);
    chk("lbu_11", mem_rdata, 32'h000000BE); tick();
    drv(1, 1, 0, 2'b01, 1, 1, 1, 5'd8, 32'h12, 32'h0);
    chk("lh_12", mem_rdata, 32'hFFFFDEAD); tick();

    // Partial stores
    drv(1, 0, 1, 2'b10, 0, 0, 0, 5'd0, 32'h13, 32'hAAAAAA55); tick();
    drv(1, 1, 0, 2'b00, 0, 1, 1, 5'd9, 32'h10, 32'h0);
    chk("sb_13", mem_rdata, 32'h55ADBEEF); tick();
    drv(1, 0, 1, 2'b01, 0, 0, 0, 5'd0, 32'h10, 32'hFFFF1234); tick();
    drv(1, 1, 0, 2'b00, 0, 1, 1, 5'd9, 32'h10, 32'h0);
    chk("sh_10", mem_rdata, 32'h55AD1234); tick();

    // Misalignment
    drv(1, 0, 1, 2'b00, 0, 0, 0, 5'd0, 32'h20, 32'hCAFEF00D); tick();
    drv(1, 0, 1, 2'b00, 0, 0, 1, 5'd3, 32'h21, 32'h12345678); tick();
    drv(1, 1, 0, 2'b00, 0, 1, 1, 5'd4, 32'h20, 32'h0);
    chk("mis_st_unch", mem_rdata, 32'hCAFEF00D);
    chk("mis_afault", 32'(afault), 32'h1);
    chk("mis_faddr", faddr, 32'h21); tick();
    drv(1, 1, 0, 2'b01, 1, 1, 1, 5'd4, 32'h33, 32'h0);
    chk("mis_ld_zero", mem_rdata, 32'h0); tick();
    drv(1, 0, 0, 2'b00, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    chk("mis_ld_rw", 32'(wb_rw), 32'h0);
    chk("mis_faddr_kept", faddr, 32'h21); tick();

    // Wrap and simultaneous access
    drv(1, 0, 1, 2'b00, 0, 0, 0, 5'd0, 32'h1000, 32'h11112222); tick();
    drv(1, 1, 0, 2'b00, 0, 1, 1, 5'd1, 32'h0, 32'h0);
    chk("wrap", mem_rdata, 32'h11112222); tick();
    drv(1, 1, 1, 2'b00, 0, 1, 1, 5'd1, 32'h0, 32'h33334444);
    chk("rdwr_old", mem_rdata, 32'h11112222); tick();
    drv(1, 1, 0, 2'b00, 0, 1, 1, 5'd1, 32'h0, 32'h0);
    chk("rdwr_new", mem_rdata, 32'h33334444); tick();

    // Reset mid-operation
    drv(1, 0, 1, 2'b00, 0, 0, 0, 5'd0, 32'h40, 32'hAAAA5555); tick();
    drv(0, 0, 1, 2'b00, 0, 1, 1, 5'd9, 32'h40, 32'h0BADF00D); tick();
    drv(1, 1, 0, 2'b00, 0, 0, 0, 5'd0, 32'h40, 32'h0);
    chk("rst_st_supp", mem_rdata, 32'hAAAA5555);
    chk("rst_wb_alu", wb_alu, 32'h0);
    chk("rst_wb_dst", 32'(wb_dst), 32'h0);
    chk("rst_wb_m2r", 32'(wb_m2r), 32'h0);
    chk("rst_faddr", faddr, 32'h0);
    chk("rst_afault2", 32'(afault), 32'h0);
    tick();

    // Randomized traffic over a small window, with random high bits to exercise wrap.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] r, a;
      logic [1:0]  sz;
      r  = $urandom();
      a  = (r & 32'hFFFFF000) | 32'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz != 2'b10) a[1:0] = 2'b00;
      end
      drv(($urandom_range(0, 59) != 0), 1'($urandom()), 1'($urandom()), sz,
          1'($urandom()), 1'($urandom()), 1'($urandom()), 5'($urandom()), a, $urandom());
      tick();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage directly downstream of the execute stage. Takes the execute-stage results (ALU result as address, store data, destination register, control bits) held in the EX/MEM register, performs word/half/byte loads and stores on a local little-endian data memory, and registers the write-back bundle into the MEM/WB register. It also drives the combinational load-data path that the execute-stage forwarding mux uses as its memory-read source. Misaligned accesses are suppressed and recorded in a sticky fault register.

## Interface
- DEPTH, 1024: data memory size in 32-bit words; power of two, at least 16.
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset.
- MemRead  in  1  load in this cycle.
- MemWrite  in  1  store in this cycle.
- MemSize  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
- MemSigned  in  1  sign-extend half/byte loads when 1, zero-extend when 0.
- MemToReg  in  1  write-back selects load data (1) or ALU result (0).
- RegWrite  in  1  instruction writes the register file.
- RegDest  in  5  destination register.
- ALUResult  in  32  byte address / ALU result.
- StoreData  in  32  store data; forwarding is already resolved upstream.
- MEM_ReadData  out  32  combinational load data for the current address. Feeds the execute-stage forwarding mux.
- WB_ReadData  out  32  registered load data.
- WB_ALUResult  out  32  registered ALU result.
- WB_RegDest  out  5  registered destination register.
- WB_RegWrite  out  1  registered write enable, after fault qualification.
- WB_MemToReg  out  1  registered write-back select.
- AlignFault  out  1  sticky misalignment flag.
- FaultAddr  out  32  address of the first misaligned access.

## Operation
- Word index = ALUResult[log2(DEPTH)+1:2]. Upper address bits are ignored, so the address wraps modulo DEPTH words.
- Byte lane = ALUResult[1:0], little-endian. Lane 0 is bits 7:0. A half-word at offset 2 occupies bits 31:16.
- Misaligned access:
  - word access with ALUResult[1:0] != 0;
  - half access with ALUResult[0] = 1;
  - byte access is never misaligned.
- Misaligned store: memory is unchanged.
- Misaligned load: MEM_ReadData = 0 and WB_RegWrite is forced to 0.
- On any misaligned access (load or store):
  - AlignFault is set;
  - FaultAddr captures ALUResult only if AlignFault was previously 0;
  - both are cleared only by Reset.
- Store writes only the addressed byte lanes: word = 4 lanes, half = 2, byte = 1. The data comes from StoreData[7:0] (byte) or [15:0] (half), replicated into the target lanes.
- Load data:
  - word: the whole word;
  - half/byte: lane data shifted to bit 0, then sign- or zero-extended per MemSigned;
  - MemRead = 0 drives MEM_ReadData = 0.
- MemRead and MemWrite both asserted: the store is performed, and MEM_ReadData returns the pre-write contents.
- WB_RegWrite = RegWrite AND NOT (misaligned AND (MemRead OR MemWrite)).

## Timing
- MEM_ReadData is combinational from address and controls; memory read is asynchronous.
- The store commits at the rising edge of Clock.
- A load to the same word in the following cycle returns the new data. In the same cycle it returns the old data.
- WB_* outputs update every rising edge; latency from inputs is 1 cycle. There is no stall or handshake, so the stage accepts one instruction per cycle.
- Reset low at an edge:
  - WB_ReadData, WB_ALUResult and FaultAddr go to 0;
  - WB_RegDest goes to 0; WB_RegWrite and WB_MemToReg go to 0;
  - AlignFault goes to 0;
  - a store presented in that cycle is suppressed;
  - memory contents are retained and not initialised.
- First edge with Reset high processes the inputs normally.

## Structure
- Shared package holds:
  - MemSize encodings (MEM_WORD, MEM_HALF, MEM_BYTE);
  - the DEPTH default;
  - the log2 helper for the index width.
- Sub-module data_memory_ram:
  - DEPTH x 32 array with 4-bit byte-enable synchronous write and asynchronous read;
  - write enable gated by Reset.
- Alignment check, lane steering, extension, fault register and MEM/WB register live in mem_stage.

## Test plan
- Word store then load:
  - store 0xDEADBEEF to 0x10;
  - next cycle load word from 0x10: MEM_ReadData = 0xDEADBEEF;
  - following cycle: WB_ReadData = 0xDEADBEEF, WB_RegWrite follows RegWrite.
- Byte/half extension, after the 0xDEADBEEF store:
  - signed byte at 0x11: 0xFFFFFFBE;
  - unsigned byte at 0x11: 0x000000BE;
  - signed half at 0x12: 0xFFFFDEAD.
- Partial stores:
  - byte store 0x55 to 0x13 over 0xDEADBEEF: word at 0x10 reads 0x55ADBEEF;
  - half store 0x1234 to 0x10 then gives 0x55AD1234.
- Misalignment:
  - word store to 0x21: memory unchanged, AlignFault = 1, FaultAddr = 0x21;
  - later half load at 0x33: MEM_ReadData = 0, WB_RegWrite = 0, FaultAddr stays 0x21.
- Wrap and simultaneous access (DEPTH=1024):
  - store to 0x1000 aliases word 0 (load from 0x0 returns it);
  - MemRead and MemWrite together return old data the same cycle and new data the next cycle.
- Reset mid-operation:
  - Reset low with a word store to 0x40 pending: memory at 0x40 unchanged;
  - all WB_* outputs, AlignFault and FaultAddr are 0 after the edge.
